// File: rtl/toggle_activity_monitor_pkg.sv
// Shared definitions for the toggle activity monitor: FSM encoding, default
// widths and the weight value every net starts with after reset.
package toggle_activity_monitor_pkg;

  localparam int unsigned DEF_NUM_NETS  = 8;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_WGT_W     = 8;
  localparam int unsigned WGT_RESET_VAL = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    COUNT = S_COUNT,
    ACCUM = S_ACCUM,
    DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/toggle_activity_monitor_toggle_cell.sv
// One monitored net: edge detector against the previous sample plus a
// saturating toggle counter.
module toggle_cell #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             net,
  output logic [CNT_W-1:0] count
);

  logic prev;

  // clear loads the reference sample so the first counted edge compares
  // against the value present when the window was started.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      count <= '0;
    end else if (clear) begin
      prev  <= net;
      count <= '0;
    end else if (en) begin
      prev <= net;
      if ((net != prev) && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Counts toggles per net over a window, then serially accumulates the
// weighted sum (power estimate) and raw toggle total, one net per cycle.
module toggle_activity_monitor
  import toggle_activity_monitor_pkg::*;
#(
  parameter int unsigned NUM_NETS = DEF_NUM_NETS,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned WGT_W    = DEF_WGT_W,
  localparam int unsigned AW      = (NUM_NETS > 1) ? $clog2(NUM_NETS) : 1,
  localparam int unsigned ACC_W   = CNT_W + WGT_W + $clog2(NUM_NETS),
  localparam int unsigned TOT_W   = CNT_W + $clog2(NUM_NETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_NETS-1:0] nets,
  input  logic                start,
  input  logic [15:0]         window_len,
  input  logic                wgt_we,
  input  logic [AW-1:0]       wgt_addr,
  input  logic [WGT_W-1:0]    wgt_data,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ACC_W-1:0]    power_est,
  output logic [TOT_W-1:0]    toggle_total
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NETS - 1);

  state_t           state;
  logic [15:0]      remain;
  logic [AW-1:0]    idx;
  logic [WGT_W-1:0] wgt [NUM_NETS];
  logic [CNT_W-1:0] cnt [NUM_NETS];
  logic             clear;
  logic             count_en;
  logic             addr_ok;
  logic [ACC_W-1:0] prod;

  assign clear     = (state == IDLE) && start;
  assign count_en  = (state == COUNT);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign addr_ok   = ({1'b0, wgt_addr} < (AW + 1)'(NUM_NETS));
  assign prod      = ACC_W'(cnt[idx]) * ACC_W'(wgt[idx]);

  for (genvar g = 0; g < NUM_NETS; g++) begin : g_cell
    toggle_cell #(.CNT_W(CNT_W)) u_cell (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .en    (count_en),
      .net   (nets[g]),
      .count (cnt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NETS; i++) begin
        wgt[i] <= WGT_W'(WGT_RESET_VAL);
      end
    end else if ((state == IDLE) && wgt_we && addr_ok) begin
      wgt[wgt_addr] <= wgt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      remain       <= '0;
      idx          <= '0;
      power_est    <= '0;
      toggle_total <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            power_est    <= '0;
            toggle_total <= '0;
            idx          <= '0;
            remain       <= window_len;
            state        <= (window_len == '0) ? ACCUM : COUNT;
          end
        end
        COUNT: begin
          remain <= remain - 16'd1;
          if (remain == 16'd1) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          power_est    <= power_est + prod;
          toggle_total <= toggle_total + TOT_W'(cnt[idx]);
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Scoreboard bench: a 16-bit and a 4-bit counter instance share stimulus;
// expected sums come from a bench-side toggle model.
module tb_toggle_activity_monitor;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst, start, wgt_we, res_ready;
  logic [7:0]  nets;
  logic [15:0] window_len;
  logic [2:0]  wgt_addr;
  logic [7:0]  wgt_data;
  logic        busy, res_valid, busy4, res_valid4;
  logic [26:0] power_est;
  logic [18:0] toggle_total;
  logic [14:0] power4;
  logic [6:0]  total4;

  toggle_activity_monitor dut (
    .clk(clk), .rst(rst), .nets(nets), .start(start), .window_len(window_len),
    .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .power_est(power_est),
    .toggle_total(toggle_total)
  );

  toggle_activity_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .nets(nets), .start(start), .window_len(window_len),
    .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data), .busy(busy4),
    .res_valid(res_valid4), .res_ready(res_ready), .power_est(power4),
    .toggle_total(total4)
  );

  always #5 clk = ~clk;

  int unsigned edges = 0;
  always @(posedge clk) edges++;

  typedef struct {
    longint p, t, p4, t4;
    int lat;
  } exp_t;
  exp_t sbq[$];

  int total_n = 0;
  int bad_n = 0;
  int wgt_m[N];
  int c16[N];
  int c4[N];
  logic [7:0] prev_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_nets(input logic [7:0] v);
    nets = v;
    for (int i = 0; i < N; i++) begin
      if (v[i] != prev_m[i]) begin
        if (c16[i] < 65535) c16[i]++;
        if (c4[i] < 15) c4[i]++;
      end
    end
    prev_m = v;
  endtask

  task automatic write_wgt(input int a, input int d);
    wgt_we = 1'b1;
    wgt_addr = a[2:0];
    wgt_data = d[7:0];
    @(negedge clk);
    wgt_we = 1'b0;
    wgt_m[a] = d;
  endtask

  // mode 0: nets static 0, 1: nets[0] toggles, 2: random each cycle
  task automatic run_window(input int w, input int mode, input int hold, input bit poke);
    exp_t e;
    int unsigned t0;
    int guard;
    logic [7:0] v;
    v = (mode == 2) ? 8'($urandom) : 8'h00;
    nets = v;
    prev_m = v;
    for (int i = 0; i < N; i++) begin
      c16[i] = 0;
      c4[i] = 0;
    end
    start = 1'b1;
    window_len = w[15:0];
    t0 = edges;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < w; i++) begin
      case (mode)
        0: v = 8'h00;
        1: v = prev_m ^ 8'h01;
        default: v = 8'($urandom);
      endcase
      set_nets(v);
      if (poke && i == 2) begin
        start = 1'b1;
        window_len = 16'd3;
        wgt_we = 1'b1;
        wgt_addr = 3'd1;
        wgt_data = 8'd200;
        res_ready = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      wgt_we = 1'b0;
      res_ready = 1'b0;
    end
    e.p = 0; e.t = 0; e.p4 = 0; e.t4 = 0;
    for (int i = 0; i < N; i++) begin
      e.p  += longint'(c16[i]) * wgt_m[i];
      e.t  += c16[i];
      e.p4 += longint'(c4[i]) * wgt_m[i];
      e.t4 += c4[i];
    end
    e.lat = w + N;
    sbq.push_back(e);

    guard = 0;
    while (!res_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    e = sbq.pop_front();
    if (!res_valid) begin
      check("res_valid_timeout", 0, 1);
      return;
    end
    check("latency", edges - t0 - 1, e.lat);
    check("power_est", power_est, e.p);
    check("toggle_total", toggle_total, e.t);
    check("valid4", res_valid4, 1);
    check("power_est4", power4, e.p4);
    check("toggle_total4", total4, e.t4);

    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        start = 1'b1;
        window_len = 16'd5;
      end
      @(negedge clk);
      start = 1'b0;
      check("hold_valid", res_valid, 1);
      check("hold_power", power_est, e.p);
      check("hold_total", toggle_total, e.t);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("accept_busy", busy, 0);
    check("accept_valid", res_valid, 0);
    check("accept_busy4", busy4, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wgt_we = 1'b0; res_ready = 1'b0;
    nets = '0; window_len = '0; wgt_addr = '0; wgt_data = '0;
    for (int i = 0; i < N; i++) wgt_m[i] = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_power", power_est, 0);
    check("rst_total", toggle_total, 0);

    run_window(10, 0, 0, 1'b0);
    run_window(20, 1, 0, 1'b0);
    write_wgt(0, 3);
    run_window(10, 1, 0, 1'b0);
    for (int i = 0; i < N; i++) write_wgt(i, $urandom_range(0, 255));
    run_window(40, 2, 5, 1'b1);
    run_window(0, 2, 0, 1'b0);

    // reset in the middle of a counting window
    nets = '0;
    start = 1'b1;
    window_len = 16'd10;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nets = nets ^ 8'h01;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) wgt_m[i] = 1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", res_valid, 0);
    check("midrst_power", power_est, 0);
    check("midrst_total", toggle_total, 0);

    rst = 1'b1;
    start = 1'b1;
    window_len = 16'd5;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_over_start", busy, 0);

    run_window(12, 2, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/toggle_activity_monitor.md
TOGGLE_ACTIVITY_MONITOR -- requirements
Module: toggle_activity_monitor

Interface
REQ-001 SHALL have parameter NUM_NETS, default 8, number of monitored nets.
REQ-002 SHALL have parameter CNT_W, default 16, per-net toggle counter width.
REQ-003 SHALL have parameter WGT_W, default 8, per-net capacitance weight width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port nets  input  NUM_NETS  monitored signals, e.g. mux a,b,c,d,sel,out.
REQ-007 SHALL have port start  input  1  begins a measurement window.
REQ-008 SHALL have port window_len  input  16  window length in cycles, sampled on start.
REQ-009 SHALL have port wgt_we  input  1  weight write strobe.
REQ-010 SHALL have port wgt_addr  input  clog2(NUM_NETS)  weight index.
REQ-011 SHALL have port wgt_data  input  WGT_W  weight value.
REQ-012 SHALL have port busy  output  1  high outside IDLE.
REQ-013 SHALL have port res_valid  output  1  result available.
REQ-014 SHALL have port res_ready  input  1  consumer accepts result.
REQ-015 SHALL have port power_est  output  ACC_W=CNT_W+WGT_W+clog2(NUM_NETS)  sum of count_i*weight_i.
REQ-016 SHALL have port toggle_total  output  CNT_W+clog2(NUM_NETS)  sum of count_i.

Function
REQ-017 SHALL implement FSM states IDLE, COUNT, ACCUM, DONE.
REQ-018 In IDLE, start=1 at edge k: capture nets as reference, latch window_len, clear counters and accumulators; go COUNT, or ACCUM if window_len=0.
REQ-019 In COUNT, each edge SHALL increment count_i when nets[i] differs from previous sample, then update the sample; after window_len such edges go ACCUM.
REQ-020 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-021 In ACCUM, one net per cycle, index 0 to NUM_NETS-1, SHALL add count_i*weight_i to power_est and count_i to toggle_total; after last index go DONE.
REQ-022 res_valid SHALL rise after edge k+window_len+NUM_NETS and stay high with power_est/toggle_total stable until res_valid&&res_ready at an edge, then go IDLE.
REQ-023 Accumulator widths SHALL be ACC_W as defined, so no overflow is possible.
REQ-024 start SHALL be ignored outside IDLE, including in DONE.
REQ-025 wgt_we SHALL write weight[wgt_addr] only in IDLE; ignored otherwise; out-of-range addr ignored.
REQ-026 res_ready in a cycle with res_valid=0 SHALL have no effect.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE from any state, aborting any window.
REQ-028 Reset values: busy=0, res_valid=0, power_est=0, toggle_total=0, all counters 0, all weights 1.
REQ-029 rst SHALL take priority over start, wgt_we and res_ready in the same cycle.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the default widths and the weight reset value (1).
REQ-031 One sub-module toggle_cell (edge detect plus saturating counter, one per net) SHALL be used, instantiated NUM_NETS times via generate.

Verification
REQ-032 Weights 1, nets held 0, window_len=10, start -> res_valid after 18 cycles, power_est=0, toggle_total=0.
REQ-033 weight[0]=3, nets[0] toggling every cycle, others static, window_len=10 -> toggle_total=10, power_est=30.
REQ-034 CNT_W=4, nets[0] toggling, window_len=20 -> count saturates, toggle_total=15, power_est=15 (weight 1).
REQ-035 Hold res_ready=0 for 5 cycles in DONE -> res_valid and outputs stable; first edge with ready=1 -> IDLE, busy=0.
REQ-036 rst pulse mid-COUNT -> next cycle IDLE, busy=0, outputs 0; start during busy ignored; window_len=0 -> result 0 after NUM_NETS+0 cycles.
